// File: rtl/rcas_rr_scheduler_pkg.sv
// Shared types and constants for the round-robin scheduler in front of the
// single rcas_4bit add/sub datapath.
package rcas_sched_pkg;

  localparam int DATA_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              sel;
  } operand_t;

endpackage

// File: rtl/rcas_rr_scheduler_if.sv
// Request/response channel bundle between the ALU-using masters and the scheduler.
interface rcas_rr_scheduler_if
  import rcas_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W*NUM_REQ-1:0] req_a;
  logic [DATA_W*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]        req_sel;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_result;
  logic                      rsp_c_out;

  modport master (
    output req_valid, req_a, req_b, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_c_out
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_c_out
  );

endinterface

// File: rtl/rcas_4bit.sv
// 4-bit ripple-carry adder/subtractor: sel=1 computes a + ~b + 1.
module rcas_4bit
  import rcas_sched_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sel,
  output logic [DATA_W-1:0] result,
  output logic              c_out
);

  logic              sub;
  logic [DATA_W:0]   carry;
  logic [DATA_W-1:0] b_eff;

  assign sub   = (sel == OP_SUB);
  assign b_eff = b ^ {DATA_W{sub}};

  always_comb begin
    carry    = '0;
    result   = '0;
    carry[0] = sub;
    for (int i = 0; i < DATA_W; i++) begin
      result[i]  = a[i] ^ b_eff[i] ^ carry[i];
      carry[i+1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
    end
  end

  assign c_out = carry[DATA_W];

endmodule

// File: rtl/rcas_rr_scheduler_arbiter.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  int              idx;
  logic [ID_W-1:0] idx_w;

  // NOTE: every output gets a default before the search loop, so no path
  // through this block leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    idx_w     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx   = (int'(ptr) + k) % NUM_REQ;
      idx_w = ID_W'(idx);
      if (!grant_any && req[idx_w]) begin
        grant[idx_w] = 1'b1;
        grant_idx    = idx_w;
        grant_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rcas_rr_scheduler.sv
// Shares one rcas_4bit between NUM_REQ requesters: IDLE grants, EXEC evaluates
// once, RESP holds the tagged result until the consumer accepts it.
module rcas_rr_scheduler
  import rcas_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rcas_rr_scheduler_if.slave   bus,
  output logic                 busy
);

  state_t            state;
  operand_t          op_q;
  operand_t          op_d;
  logic [ID_W-1:0]   id_q;
  // ptr is the search start, i.e. last grant + 1; zero after reset.
  logic [ID_W-1:0]   ptr;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;

  logic [DATA_W-1:0]  alu_result;
  logic               alu_c_out;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (bus.req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Ready is held low while reset is asserted even though state already reads IDLE.
  assign bus.req_ready = (state == IDLE && rst_n) ? grant : '0;

  always_comb begin
    op_d.a   = bus.req_a[int'(grant_idx)*DATA_W +: DATA_W];
    op_d.b   = bus.req_b[int'(grant_idx)*DATA_W +: DATA_W];
    op_d.sel = bus.req_sel[grant_idx];
  end

  rcas_4bit u_alu (
    .a      (op_q.a),
    .b      (op_q.b),
    .sel    (op_q.sel),
    .result (alu_result),
    .c_out  (alu_c_out)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      op_q           <= '0;
      id_q           <= '0;
      ptr            <= '0;
      busy           <= 1'b0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_id     <= '0;
      bus.rsp_result <= '0;
      bus.rsp_c_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            op_q  <= op_d;
            id_q  <= grant_idx;
            ptr   <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          bus.rsp_result <= alu_result;
          bus.rsp_c_out  <= alu_c_out;
          bus.rsp_id     <= id_q;
          bus.rsp_valid  <= 1'b1;
          state          <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          bus.rsp_valid <= 1'b0;
          busy          <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rcas_rr_scheduler.sv
// Directed bench for rcas_rr_scheduler with a round-robin model and an
// in-order response scoreboard.
module tb_rcas_rr_scheduler;
  import rcas_sched_pkg::*;

  localparam int N   = 2;
  localparam int IDW = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  rcas_rr_scheduler_if #(.NUM_REQ(N), .ID_W(IDW)) bus ();

  rcas_rr_scheduler #(.NUM_REQ(N), .ID_W(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  typedef struct {
    int         id;
    logic [3:0] res;
    logic       c;
  } exp_t;

  exp_t         sb[$];
  int           grant_log[$];
  int           model_ptr = 0;
  logic [N-1:0] last_hs;
  int           checks = 0;
  int           errors = 0;
  int           cnt[N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int p, input logic [N-1:0] v);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (p + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  // Reference carry: a + (b ^ {4{sel}}) + sel in 5 bits.
  function automatic logic ref_c(input logic [3:0] a, input logic [3:0] b, input logic s);
    logic [4:0] sum;
    sum = {1'b0, a} + {1'b0, b ^ {4{s}}} + {4'b0, s};
    return sum[4];
  endfunction

  task automatic set_req(input int i, input logic v, input logic [3:0] a,
                         input logic [3:0] b, input logic s);
    bus.req_valid[i]     = v;
    bus.req_a[4*i +: 4]  = a;
    bus.req_b[4*i +: 4]  = b;
    bus.req_sel[i]       = s;
  endtask

  task automatic observe();
    logic [N-1:0] hs;
    logic [N-1:0] exp_oh;
    logic [3:0]   a, b;
    logic         s;
    int           g;
    exp_t         e;
    last_hs = '0;
    if (!rst_n) return;
    hs      = bus.req_valid & bus.req_ready;
    last_hs = hs;
    check("ready_onehot0", 32'($onehot0(bus.req_ready)), 1);
    if (hs != '0) begin
      g      = rr_pick(model_ptr, bus.req_valid);
      exp_oh = '0;
      if (g >= 0) exp_oh[g] = 1'b1;
      check("grant", 32'(bus.req_ready), 32'(exp_oh));
      if (g >= 0) begin
        a     = bus.req_a[4*g +: 4];
        b     = bus.req_b[4*g +: 4];
        s     = bus.req_sel[g];
        e.id  = g;
        e.res = s ? a - b : a + b;
        e.c   = ref_c(a, b, s);
        sb.push_back(e);
        grant_log.push_back(g);
        model_ptr = (g + 1) % N;
      end
    end
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'(bus.rsp_valid), 0);
      end else begin
        e = sb.pop_front();
        check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
        check("rsp_result", 32'(bus.rsp_result), 32'(e.res));
        check("rsp_c_out", 32'(bus.rsp_c_out), 32'(e.c));
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while ((sb.size() != 0 || bus.rsp_valid) && n < max_cycles) begin
      cycle();
      n++;
    end
    check("drain_timeout", 32'(sb.size()), 0);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    sb.delete();
    grant_log.delete();
    model_ptr = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sel   = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    #12;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_id", 32'(bus.rsp_id), 0);
    check("rst_rsp_result", 32'(bus.rsp_result), 0);
    check("rst_rsp_c_out", 32'(bus.rsp_c_out), 0);
    check("rst_busy", 32'(busy), 0);
    bus.req_valid = '1;
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 0);
    bus.req_valid = '0;
    reset_dut();

    // Single add on req0, latency and operand isolation
    set_req(0, 1'b1, 4'h7, 4'h5, OP_ADD);
    bus.rsp_ready = 1'b1;
    #1;
    check("t1_ready", 32'(bus.req_ready), 1);
    cycle();
    set_req(0, 1'b0, 4'hF, 4'hF, OP_SUB);
    #1;
    check("t1_exec_valid", 32'(bus.rsp_valid), 0);
    check("t1_exec_busy", 32'(busy), 1);
    check("t1_exec_ready", 32'(bus.req_ready), 0);
    cycle();
    check("t1_rsp_valid", 32'(bus.rsp_valid), 1);
    check("t1_rsp_id", 32'(bus.rsp_id), 0);
    check("t1_rsp_result", 32'(bus.rsp_result), 32'h0000_000C);
    cycle();
    check("t1_idle_valid", 32'(bus.rsp_valid), 0);
    check("t1_idle_busy", 32'(busy), 0);

    // Subtract with wrap on req1
    set_req(1, 1'b1, 4'h3, 4'h5, OP_SUB);
    #1;
    check("t2_ready", 32'(bus.req_ready), 2);
    cycle();
    set_req(1, 1'b0, 4'h0, 4'h0, OP_ADD);
    cycle();
    check("t2_rsp_valid", 32'(bus.rsp_valid), 1);
    check("t2_rsp_id", 32'(bus.rsp_id), 1);
    check("t2_rsp_result", 32'(bus.rsp_result), 32'h0000_000E);
    check("t2_rsp_c_out", 32'(bus.rsp_c_out), 32'(ref_c(4'h3, 4'h5, OP_SUB)));
    cycle();

    // Contention from reset: grants alternate 0,1,0,1
    set_req(0, 1'b1, 4'h9, 4'h8, OP_ADD);
    set_req(1, 1'b1, 4'h2, 4'h7, OP_SUB);
    reset_dut();
    repeat (12) cycle();
    bus.req_valid = '0;
    drain(10);
    check("t3_grant_count", 32'(grant_log.size() >= 4), 1);
    for (int k = 0; k < 4; k++) check("t3_rr_order", 32'(grant_log[k]), 32'(k % 2));

    // Backpressure: response held, no new grant
    set_req(0, 1'b1, 4'hF, 4'h1, OP_ADD);
    set_req(1, 1'b1, 4'h0, 4'h1, OP_SUB);
    bus.rsp_ready = 1'b0;
    begin
      int n = 0;
      while (!bus.rsp_valid && n < 10) begin
        cycle();
        n++;
      end
    end
    check("t4_rsp_valid", 32'(bus.rsp_valid), 1);
    check("t4_sb_depth", 32'(sb.size()), 1);
    repeat (10) begin
      cycle();
      check("t4_hold_valid", 32'(bus.rsp_valid), 1);
      check("t4_hold_id", 32'(bus.rsp_id), 32'(sb[0].id));
      check("t4_hold_result", 32'(bus.rsp_result), 32'(sb[0].res));
      check("t4_hold_c_out", 32'(bus.rsp_c_out), 32'(sb[0].c));
      check("t4_hold_ready", 32'(bus.req_ready), 0);
      check("t4_hold_busy", 32'(busy), 1);
    end
    bus.rsp_ready = 1'b1;
    cycle();
    check("t4_next_ready", 32'($onehot(bus.req_ready)), 1);
    cycle();
    check("t4_next_busy", 32'(busy), 1);
    bus.req_valid = '0;
    drain(10);

    // Reset during EXEC discards the op and returns the pointer to 0
    set_req(0, 1'b1, 4'h6, 4'h6, OP_ADD);
    set_req(1, 1'b0, 4'h0, 4'h0, OP_ADD);
    #1;
    cycle();
    set_req(0, 1'b0, 4'h0, 4'h0, OP_ADD);
    rst_n = 1'b0;
    sb.delete();
    grant_log.delete();
    model_ptr = 0;
    #1;
    check("t5_rst_valid", 32'(bus.rsp_valid), 0);
    check("t5_rst_busy", 32'(busy), 0);
    repeat (3) begin
      cycle();
      check("t5_rst_hold_valid", 32'(bus.rsp_valid), 0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      cycle();
      check("t5_post_valid", 32'(bus.rsp_valid), 0);
    end
    set_req(0, 1'b1, 4'h4, 4'h2, OP_SUB);
    set_req(1, 1'b1, 4'h1, 4'h1, OP_ADD);
    #1;
    check("t5_ptr_zero", 32'(bus.req_ready), 1);
    cycle();
    bus.req_valid = '0;
    drain(10);

    // Exhaustive operands on every requester, random valid drops and backpressure
    for (int i = 0; i < N; i++) cnt[i] = 0;
    begin
      int guard = 0;
      while ((cnt[0] < 512 || cnt[1] < 512) && guard < 20000) begin
        for (int i = 0; i < N; i++) begin
          logic [8:0] k;
          k = cnt[i][8:0];
          set_req(i, (cnt[i] < 512) && ($urandom_range(0, 7) != 0), k[3:0], k[7:4], k[8]);
        end
        bus.rsp_ready = ($urandom_range(0, 3) != 0);
        cycle();
        for (int i = 0; i < N; i++) if (last_hs[i]) cnt[i]++;
        guard++;
      end
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    drain(20);
    for (int i = 0; i < N; i++) check("t6_done", 32'(cnt[i]), 512);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
